// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int CLK_DIV_DEF = 434;
  localparam int DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-to-FIFO output bundle: byte, write strobe, framing error, busy.
interface uart_rx_os_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx_data, output rx_valid, output frame_err, output busy);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with 3-sample majority vote and framing-error report.
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | timing the start bit, rejecting glitches at its centre
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit; leaves mid-bit so a following start is not missed
//   BREAK | stop bit was low, waiting for the line to return high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rxd,
  uart_rx_os_if.master   rx_if
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(HALF);
  localparam logic [CW-1:0] SMP_C    = CW'(HALF + 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic rxs;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 decide;
  logic                 maj;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // third sample is taken live at the decision point
    decide = (cnt_q == SMP_C);
    maj    = maj3(smp_q[0], smp_q[1], rxs);
    if (cnt_q == SMP_A) smp_d[0] = rxs;
    if (cnt_q == SMP_B) smp_d[1] = rxs;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (cnt_q == CNT_LAST) begin
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      smp_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state_q != IDLE);

endmodule
